// File: rtl/computer_pkg.sv
// computer_pkg: shared constants and state types for the UART banner/echo controller
package computer_pkg;
    localparam int CLKS_PER_BIT_DEFAULT = 100_000_000 / 115200;
    localparam logic [3:0][7:0] BANNER_BYTES = {8'h0A, 8'h0D, 8'h4B, 8'h4F};
    typedef enum logic {BANNER, ECHO} ctl_state_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with start-glitch rejection and one-cycle valid pulse
module uart_rx
    import computer_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    uart_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic s1, s2, s3, half, full;
    assign half = cnt == HALF;
    assign full = cnt == LAST;
    assign data = shreg;
    // s1/s2 synchronize the line; s3 is the previous synchronized value for edge detection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = s3 && !s2 ? START : IDLE;
            START: state_nx = half ? (s2 ? IDLE : DATA) : START;
            DATA:  state_nx = full && bit_idx == 3'd7 ? STOP : DATA;
            STOP:  state_nx = full ? IDLE : STOP;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            valid        <= 1'b0;
            {s3, s2, s1} <= 3'b111;
        end else begin
            state        <= state_nx;
            {s3, s2, s1} <= {s2, s1, rx};
            cnt          <= state == IDLE || (state == START ? half : full) ? '0 : cnt + 1'b1;
            bit_idx      <= state == DATA && full ? bit_idx + 1'b1 : bit_idx;
            shreg        <= state == DATA && full ? {s2, shreg[7:1]} : shreg;
            valid        <= state == STOP && full && s2;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with load/busy handshake
module uart_tx
    import computer_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    uart_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic last;
    assign last = cnt == LAST;
    assign busy = state != IDLE;
    // decoded from state so an asserted reset idles the line without waiting for an edge
    assign tx = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = load ? START : IDLE;
            START: state_nx = last ? DATA : START;
            DATA:  state_nx = last && bit_idx == 3'd7 ? STOP : DATA;
            STOP:  state_nx = last ? IDLE : STOP;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= state == IDLE || last ? '0 : cnt + 1'b1;
            bit_idx <= state == DATA && last ? bit_idx + 1'b1 : bit_idx;
            shreg   <= state == IDLE && load ? data : state == DATA && last ? shreg >> 1 : shreg;
        end
    end
endmodule

// File: rtl/computer.sv
// computer: UART controller that sends "OK\r\n" after reset, then echoes received bytes
module computer
    import computer_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic UART_RX,
    output logic UART_TX
);
    ctl_state_t state, state_nx;
    logic [2:0] idx;
    logic armed, buf_full, tx_load, tx_busy, rx_valid;
    logic [7:0] buf_data, tx_data, rx_data;
    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .load  (tx_load),
        .data  (tx_data),
        .busy  (tx_busy),
        .tx    (UART_TX)
    );
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .rx    (UART_RX),
        .data  (rx_data),
        .valid (rx_valid)
    );
    always_comb begin
        state_nx = state == BANNER && idx == 3'd4 && !tx_busy ? ECHO : state;
        tx_load  = !tx_busy && (state == BANNER ? armed && idx != 3'd4 : buf_full);
        tx_data  = state == BANNER ? BANNER_BYTES[idx[1:0]] : buf_data;
    end
    // armed holds the first banner load back by one cycle after reset release
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state    <= BANNER;
            idx      <= '0;
            armed    <= 1'b0;
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            idx   <= state == BANNER && tx_load ? idx + 1'b1 : idx;
            if (state == ECHO && tx_load)
                buf_full <= 1'b0;
            else if (rx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= rx_data;
            end
        end
    end
endmodule

// File: tb/tb_computer.sv
// tb_computer: directed banner, reset, echo, framing, glitch and overrun checks at 16 clocks per bit
module tb_computer;
    localparam int CPB = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx;
    int checks = 0;
    int errors = 0;
    logic [7:0] banner [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};

    computer #(.CLK_FREQ(1_843_200), .BAUD(115200)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .UART_RX    (rx),
        .UART_TX    (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // waits up to budget negedges for a start bit, then samples the whole frame every cycle
    task automatic recv(input int budget, output logic [7:0] b, output logic good, output int waited);
        logic [10*CPB-1:0] smp;
        b = '0;
        good = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < budget);
        if (tx !== 1'b0) begin
            waited = -1;
            return;
        end
        smp[0] = tx;
        for (int i = 1; i < 10*CPB; i++) begin
            @(negedge clk);
            smp[i] = tx;
        end
        good = smp[0] == 1'b0 && smp[9*CPB] == 1'b1;
        for (int k = 0; k < 10; k++)
            for (int c = 1; c < CPB; c++)
                if (smp[k*CPB+c] !== smp[k*CPB]) good = 1'b0;
        for (int k = 0; k < 8; k++) b[k] = smp[(k+1)*CPB];
    endtask

    task automatic skip_banner();
        logic [7:0] b;
        logic g;
        int w;
        do_reset();
        for (int i = 0; i < 4; i++) recv(4, b, g, w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL tx_after_edge1 got %b want 1", tx); end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL tx_after_edge2 got %b want 0", tx); end
    endtask

    task automatic test_banner();
        logic [7:0] b;
        logic g;
        int w, lows;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            recv(4, b, g, w);
            checks += 3;
            if (w !== 2) begin errors++; $display("FAIL banner_wait%0d got %0d want 2", i, w); end
            if (b !== banner[i]) begin errors++; $display("FAIL banner_byte%0d got %h want %h", i, b, banner[i]); end
            if (g !== 1'b1) begin errors++; $display("FAIL banner_frame%0d got %b want 1", i, g); end
        end
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL banner_idle_lows got %0d want 0", lows); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        logic g;
        int w, lows;
        do_reset();
        recv(4, b, g, w);
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx got %b want 1", tx); end
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL midreset_lows got %0d want 0", lows); end
        rst_n = 1'b1;
        recv(4, b, g, w);
        checks += 2;
        if (w !== 2) begin errors++; $display("FAIL restart_wait got %0d want 2", w); end
        if (b !== 8'h4F) begin errors++; $display("FAIL restart_byte got %h want 4f", b); end
    endtask

    task automatic test_echo();
        logic [7:0] b;
        logic g;
        int w;
        skip_banner();
        fork
            send_rx(8'hA5, 1'b1);
            recv(CPB*19/2 + 40, b, g, w);
        join
        checks += 3;
        if (w < 1 || w > CPB*19/2 + 5) begin errors++; $display("FAIL echo_latency got %0d want 1..%0d", w, CPB*19/2 + 5); end
        if (b !== 8'hA5) begin errors++; $display("FAIL echo_byte got %h want a5", b); end
        if (g !== 1'b1) begin errors++; $display("FAIL echo_frame got %b want 1", g); end
    endtask

    task automatic test_overlap();
        logic [7:0] b;
        logic g;
        int w;
        do_reset();
        fork
            begin
                repeat (20) @(negedge clk);
                send_rx(8'h31, 1'b1);
                send_rx(8'h77, 1'b1);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    recv(4, b, g, w);
                    checks++;
                    if (b !== banner[i]) begin errors++; $display("FAIL overlap_banner%0d got %h want %h", i, b, banner[i]); end
                end
                recv(4, b, g, w);
                checks += 2;
                if (w !== 3) begin errors++; $display("FAIL overlap_gap got %0d want 3", w); end
                if (b !== 8'h31) begin errors++; $display("FAIL overlap_echo got %h want 31", b); end
            end
        join
        recv(300, b, g, w);
        checks++;
        if (w !== -1) begin errors++; $display("FAIL overrun_drop got byte %h want none", b); end
    endtask

    task automatic test_framing();
        logic [7:0] b;
        logic g;
        int w;
        skip_banner();
        send_rx(8'h12, 1'b0);
        recv(100, b, g, w);
        checks++;
        if (w !== -1) begin errors++; $display("FAIL framing_drop got byte %h want none", b); end
        fork
            send_rx(8'h34, 1'b1);
            recv(200, b, g, w);
        join
        checks++;
        if (b !== 8'h34) begin errors++; $display("FAIL framing_next got %h want 34", b); end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        logic g;
        int w;
        skip_banner();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        recv(150, b, g, w);
        checks++;
        if (w !== -1) begin errors++; $display("FAIL glitch_drop got byte %h want none", b); end
        fork
            send_rx(8'h5A, 1'b1);
            recv(200, b, g, w);
        join
        checks++;
        if (b !== 8'h5A) begin errors++; $display("FAIL glitch_next got %h want 5a", b); end
    endtask

    initial begin
        test_reset();
        test_banner();
        test_mid_reset();
        test_echo();
        test_overlap();
        test_framing();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
